// File: rtl/ascon_pkg.sv
// ascon_pkg: shared state encoding, field sizes and counter width for the ASCON input loader
package ascon_pkg;
  localparam int KEY_BYTES = 16;
  localparam int NONCE_BYTES = 16;
  localparam int CNT_W = 5;
  typedef enum logic [2:0] {LOAD_KEY, LOAD_NONCE, LOAD_AD, LOAD_PT, FIRE, WAIT_FIN} state_t;
  function automatic logic is_load(state_t s);
    return s inside {LOAD_KEY, LOAD_NONCE, LOAD_AD, LOAD_PT};
  endfunction
  // Load states are consecutive, so the field after the last one is FIRE
  function automatic state_t advance(state_t s);
    return state_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/ascon_input_loader_if.sv
// ascon_input_loader_if: 8-bit valid/ready byte stream with end-of-frame marker
interface ascon_input_loader_if;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [7:0] in_data;
  modport master(output in_valid, in_data, in_last, input in_ready);
  modport slave(input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/ascon_input_loader_byte_shift_reg.sv
// byte_shift_reg: left-shifting byte accumulator, first byte ends in the MSB
module byte_shift_reg #(
  parameter int BYTES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [7:0]         din,
  output logic [8*BYTES-1:0] q
);
  localparam int W = 8 * BYTES;
  always_ff @(posedge clk)
    if (!rst || clr) q <= '0;
    else if (en) q <= W'({q, din});
endmodule

// File: rtl/ascon_input_loader.sv
// ascon_input_loader: byte-serial frame loader and start sequencer for the ASCON encryption core.
// Define ASCON_LOADER_ZEROIZE_EN to clear the key after each operation and on frame errors.
module ascon_input_loader
  import ascon_pkg::*;
#(
  parameter int AD_BYTES = 5,
  parameter int PT_BYTES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ascon_input_loader_if.slave   stream,
  output logic [127:0]          key,
  output logic [127:0]          nonce,
  output logic [8*AD_BYTES-1:0] ad,
  output logic [8*PT_BYTES-1:0] pt,
  output logic                  encryption_start,
  input  logic                  encryption_fin,
  output logic                  busy,
  output logic                  frame_err
);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, field_last;
  logic ready_q, accept, field_done, err, load, key_clr;

  assign stream.in_ready = ready_q;
  assign accept = stream.in_valid && ready_q;
  assign field_last = state == LOAD_KEY   ? CNT_W'(KEY_BYTES - 1)
                    : state == LOAD_NONCE ? CNT_W'(NONCE_BYTES - 1)
                    : state == LOAD_AD    ? CNT_W'(AD_BYTES - 1)
                    :                       CNT_W'(PT_BYTES - 1);
  assign field_done = cnt == field_last;
  // in_last must coincide exactly with the final PT byte; any disagreement aborts the frame
  assign err = accept && (stream.in_last != (state == LOAD_PT && field_done));
  assign load = accept && !err;
  assign encryption_start = state == FIRE;
  assign busy = state inside {FIRE, WAIT_FIN};

`ifdef ASCON_LOADER_ZEROIZE_EN
  assign key_clr = err || (state == WAIT_FIN && encryption_fin);
`else
  assign key_clr = 1'b0;
`endif

  always_comb begin
    state_d = err                               ? LOAD_KEY
            : accept                            ? (field_done ? advance(state) : state)
            : state == FIRE                     ? WAIT_FIN
            : state == WAIT_FIN && encryption_fin ? LOAD_KEY
            :                                     state;
    cnt_d = (err || (accept && field_done)) ? '0 : accept ? cnt + 1'b1 : cnt;
  end

  always_ff @(posedge clk)
    if (!rst) begin
      state <= LOAD_KEY;
      cnt <= '0;
      ready_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      ready_q <= is_load(state_d);
      frame_err <= err;
    end

  byte_shift_reg #(.BYTES(KEY_BYTES)) u_key (
    .clk(clk), .rst(rst), .en(load && state == LOAD_KEY), .clr(key_clr), .din(stream.in_data), .q(key)
  );
  byte_shift_reg #(.BYTES(NONCE_BYTES)) u_nonce (
    .clk(clk), .rst(rst), .en(load && state == LOAD_NONCE), .clr(1'b0), .din(stream.in_data), .q(nonce)
  );
  byte_shift_reg #(.BYTES(AD_BYTES)) u_ad (
    .clk(clk), .rst(rst), .en(load && state == LOAD_AD), .clr(1'b0), .din(stream.in_data), .q(ad)
  );
  byte_shift_reg #(.BYTES(PT_BYTES)) u_pt (
    .clk(clk), .rst(rst), .en(load && state == LOAD_PT), .clr(1'b0), .din(stream.in_data), .q(pt)
  );
endmodule

// File: tb/tb_ascon_input_loader.sv
// tb_ascon_input_loader: randomized frames checked against a serialize/expect reference model
module tb_ascon_input_loader;
  import ascon_pkg::*;
  localparam int AD_BYTES = 5;
  localparam int PT_BYTES = 5;
  localparam int FRAME = KEY_BYTES + NONCE_BYTES + AD_BYTES + PT_BYTES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fin = 1'b0;
  logic [127:0] key, nonce;
  logic [8*AD_BYTES-1:0] ad;
  logic [8*PT_BYTES-1:0] pt;
  logic start, busy, frame_err;

  logic [127:0] ek, en;
  logic [8*AD_BYTES-1:0] ea;
  logic [8*PT_BYTES-1:0] ep;
  logic [7:0] fb [FRAME];
  int n_checks = 0;
  int n_errors = 0;
  int starts = 0;
  int exp_starts = 0;

  ascon_input_loader_if bus();

  ascon_input_loader #(.AD_BYTES(AD_BYTES), .PT_BYTES(PT_BYTES)) dut (
    .clk(clk), .rst(rst), .stream(bus), .key(key), .nonce(nonce), .ad(ad), .pt(pt),
    .encryption_start(start), .encryption_fin(fin), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (start) starts++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: the frame is the four operands serialized MSB byte first
  task automatic build(input logic [127:0] k, input logic [127:0] n,
                       input logic [8*AD_BYTES-1:0] a, input logic [8*PT_BYTES-1:0] p);
    ek = k; en = n; ea = a; ep = p;
    for (int i = 0; i < KEY_BYTES; i++) fb[i] = k[127-8*i -: 8];
    for (int i = 0; i < NONCE_BYTES; i++) fb[KEY_BYTES+i] = n[127-8*i -: 8];
    for (int i = 0; i < AD_BYTES; i++) fb[32+i] = a[8*AD_BYTES-1-8*i -: 8];
    for (int i = 0; i < PT_BYTES; i++) fb[32+AD_BYTES+i] = p[8*PT_BYTES-1-8*i -: 8];
  endtask

  task automatic build_random();
    build(rand128(), rand128(), {8'($urandom), $urandom}, {8'($urandom), $urandom});
  endtask

  task automatic send(input int n, input int last_at, input int pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) >= pct) begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'($urandom);
        bus.in_last = 1'($urandom);
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data = fb[i];
      bus.in_last = (i == last_at);
      for (int t = 0; !bus.in_ready; t++) begin
        if (t == 50) begin
          check("ready_timeout", bus.in_ready, 1);
          break;
        end
        step();
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic run_frame(input int pct);
    send(FRAME, FRAME - 1, pct);
    exp_starts++;
    check("start_pulse", start, 1);
    check("busy_fire", busy, 1);
    check("ready_fire", bus.in_ready, 0);
    check("no_frame_err", frame_err, 0);
    step();
    check("start_single", start, 0);
    check("busy_wait", busy, 1);
    check("key", key, ek);
    check("nonce", nonce, en);
    check("ad", ad, ea);
    check("pt", pt, ep);
    check("start_count", starts, exp_starts);
  endtask

  task automatic wait_fin_phase();
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom);
      bus.in_last = 1'($urandom);
      step();
      check("ready_wait", bus.in_ready, 0);
      check("busy_hold", busy, 1);
      check("key_hold", key, ek);
      check("nonce_hold", nonce, en);
      check("pt_hold", pt, ep);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    fin = 1'b1;
    step();
    fin = 1'b0;
    check("ready_after_fin", bus.in_ready, 1);
    check("busy_after_fin", busy, 0);
`ifdef ASCON_LOADER_ZEROIZE_EN
    check("key_zeroized", key, 0);
`else
    check("key_kept", key, ek);
`endif
    check("nonce_after_fin", nonce, en);
    check("ad_after_fin", ad, ea);
  endtask

  task automatic check_err_cycle();
    check("frame_err_pulse", frame_err, 1);
    check("err_no_start", start, 0);
    check("err_busy", busy, 0);
    check("err_ready", bus.in_ready, 1);
`ifdef ASCON_LOADER_ZEROIZE_EN
    check("err_key_zeroized", key, 0);
`else
    check("err_key_kept", key, ek);
`endif
    step();
    check("frame_err_single", frame_err, 0);
    check("err_start_count", starts, exp_starts);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    repeat (3) step();
    check("rst_ready", bus.in_ready, 0);
    check("rst_key", key, 0);
    check("rst_pt", pt, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_err", frame_err, 0);
    rst = 1'b1;
    step();
    check("ready_after_rst", bus.in_ready, 1);
    fin = 1'b1;
    step();
    fin = 1'b0;
    check("stray_fin_busy", busy, 0);
    check("stray_fin_ready", bus.in_ready, 1);

    build(128'h3ffa75efbd1705fa8f9ced62e5bb0be3, 128'h9691163337dd55217ea2a6b21eaa19b2,
          40'h4153434f4e, 40'h6173636f6e);
    run_frame(100);
    wait_fin_phase();
    run_frame(50);
    wait_fin_phase();

    for (int f = 0; f < 4; f++) begin
      build_random();
      run_frame(int'($urandom_range(100, 30)));
      wait_fin_phase();
    end

    build_random();
    send(20, 19, 100);
    check_err_cycle();
    build_random();
    run_frame(70);
    wait_fin_phase();

    build_random();
    send(FRAME, -1, 100);
    check_err_cycle();
    build_random();
    run_frame(100);
    wait_fin_phase();

    build_random();
    send(10, -1, 100);
    rst = 1'b0;
    step();
    check("mid_rst_key", key, 0);
    check("mid_rst_nonce", nonce, 0);
    check("mid_rst_ad", ad, 0);
    check("mid_rst_pt", pt, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", start, 0);
    check("mid_rst_err", frame_err, 0);
    rst = 1'b1;
    step();
    check("ready_after_mid_rst", bus.in_ready, 1);
    build_random();
    run_frame(60);
    wait_fin_phase();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ascon_input_loader.md
# ascon_input_loader

Byte-serial front end for the ASCON `encryption` core. It accepts one frame per operation over an 8-bit valid/ready stream: key, nonce, associated data, then plaintext. It assembles these into the core's parallel `key`/`nonce`/`ad`/`pt` inputs and pulses `encryption_start`. It then holds all operands stable until the core raises `encryption_fin`, and only then accepts the next frame.

## Interface
- `AD_BYTES`, 5, associated-data length in bytes; `ad` width = 8*AD_BYTES
- `PT_BYTES`, 5, plaintext length in bytes; `pt` width = 8*PT_BYTES
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-low reset
- `in_valid` in 1: byte on `in_data` is valid
- `in_ready` out 1: loader accepts a byte; transfer when `in_valid && in_ready`
- `in_data` in 8: frame byte
- `in_last` in 1: marks the final byte of a frame
- `key` out 128: to core
- `nonce` out 128: to core
- `ad` out 8*AD_BYTES: to core
- `pt` out 8*PT_BYTES: to core
- `encryption_start` out 1: one-cycle start pulse to core
- `encryption_fin` in 1: core completion
- `busy` out 1: high from FIRE through WAIT_FIN
- `frame_err` out 1: one-cycle pulse on a malformed frame

## Operation
- Frame order: 16 key bytes, 16 nonce bytes, AD_BYTES AD bytes, PT_BYTES PT bytes. Frame length is 42 bytes at the defaults.
- Within each field, the first byte received lands in the MSB. Each accepted byte shifts the field left by 8 and enters at the LSB.
- FSM states: LOAD_KEY, LOAD_NONCE, LOAD_AD, LOAD_PT, FIRE, WAIT_FIN.
- One byte counter, 5 bits wide. It is cleared on every state change and counts accepted bytes in the current field. The field is complete when count reaches the field length minus 1 on an accepted byte.
- LOAD_* states: `in_ready`=1. On the last byte of a field, advance to the next LOAD_* state. After the last PT byte, go to FIRE.
- `in_last` rules:
  - Required on the last PT byte.
  - `in_last` on any other byte, or its absence on the last PT byte: pulse `frame_err`, discard the frame, go to LOAD_KEY.
  - On error, field registers keep their partial contents. No start is issued.
- FIRE: `encryption_start`=1 for exactly this cycle, `in_ready`=0. Unconditionally advance to WAIT_FIN.
- WAIT_FIN: `in_ready`=0. `key`/`nonce`/`ad`/`pt` are frozen. When `encryption_fin`=1, go to LOAD_KEY.
- `encryption_fin` is sampled only in WAIT_FIN. If it is asserted in any other state, it is ignored.
- `in_valid` low in LOAD_* states: no state change; the counter holds.
- Reset values: all operand outputs 0, `encryption_start` 0, `frame_err` 0, `busy` 0, `in_ready` 0 during reset, state LOAD_KEY, counter 0.
- Reset asserted mid-frame or in WAIT_FIN: return to the reset state on the next edge. A core start that is already in flight is not tracked.

## Timing
- `in_ready` is a registered function of state, so it is high the first cycle after reset deasserts.
- Sustained throughput: 1 byte/cycle.
- Last PT byte accepted at edge N: `encryption_start` is high in cycle N+1, and `busy` rises at N+1.
- `encryption_fin` seen high at edge M in WAIT_FIN: `busy`=0 and `in_ready`=1 from cycle M+1.
- Minimum frame-to-start latency: 42 cycles at the default parameters.
- `frame_err` is asserted in the cycle after the offending byte's handshake.

## Configuration
- `ASCON_LOADER_ZEROIZE_EN` defined:
  - The `key` register clears to 0 on the edge leaving WAIT_FIN.
  - The `key` register also clears to 0 on any `frame_err`.
  - `nonce`, `ad` and `pt` are unaffected.
- Undefined: `key` retains its last value until it is overwritten by the next frame.

## Structure
- Shared package `ascon_pkg`:
  - State enum.
  - Constants `KEY_BYTES`=16 and `NONCE_BYTES`=16.
  - Byte-counter width.
- A sub-module is natural: `byte_shift_reg`, a parameterised left-shift byte accumulator with a load enable and a clear. Instantiate it four times, once each for key, nonce, AD and PT.

## Test plan
- Send key 3ffa75efbd1705fa8f9ced62e5bb0be3, nonce 9691163337dd55217ea2a6b21eaa19b2, AD 4153434f4e, PT 6173636f6e with `in_valid` held high and `in_last` on byte 42:
  - Operands match exactly.
  - `encryption_start` is a single-cycle pulse one cycle after byte 42.
- Same frame with `in_valid` de-asserted randomly (about 50%): identical operands and a single start pulse.
- Frame with `in_last` on byte 20: `frame_err` pulse and no start. The next valid frame completes normally.
- Frame with `in_last` missing on byte 42: `frame_err` pulse and no start. The state returns to LOAD_KEY.
- In WAIT_FIN, offer bytes and toggle inputs: `in_ready`=0 and operands are stable.
  - `encryption_fin` pulsed for 1 cycle: `in_ready`=1 next cycle.
  - With `ASCON_LOADER_ZEROIZE_EN` defined: `key`=0 next cycle.
- Assert `rst`=0 after 10 bytes: all outputs are 0 next edge. A full frame then loads correctly.
